// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative AES-128 decryption core.
// Contents: round count NR, forward/inverse S-box tables, round constants,
// the controller state enum and small GF(2^8) / key-word helpers.
// State ordering: byte 0 sits at bits [127:120] and the state is column-major.
// Byte i is therefore at bits [127-8*i -: 8], and column c holds bytes 4c..4c+3.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    KEXP,
    ARK0,
    ROUND,
    FINAL
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36
  };

  // Round constant lookup; counter values outside 1..10 give zero.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (enough for the 09/0b/0d/0e InvMixColumns terms).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_col.sv
// Combinational InvMixColumns over the full 128-bit state.
// Ports:
//   state_i  128  input state, byte 0 at [127:120], column-major
//   state_o  128  state after InvMixColumns on all four columns
module inv_mix_col
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_i[127-32*c -: 8];
    assign a1 = state_i[119-32*c -: 8];
    assign a2 = state_i[111-32*c -: 8];
    assign a3 = state_i[103-32*c -: 8];

    assign state_o[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
    assign state_o[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
    assign state_o[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
    assign state_o[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core. The key schedule is expanded forward to
// round key 10, then walked backwards one round key per cycle alongside the
// inverse rounds, so no round-key storage is needed.
// Optional build macro: AES_INV_KEY_CACHE_EN keeps the last expanded key and
// its round key 10 so a repeated key skips forward expansion (11-cycle latency).
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   ct     128   ciphertext, byte 0 at [127:120], column-major
//   key    128   cipher key (round-0 key), same ordering
//   pt     128   plaintext, updated with done and held afterwards
//   busy         high whenever the controller is not idle
//   done         one-cycle completion pulse
//   dbg_state_o  current controller state
// Handshake: start is a request accepted on any rising edge where busy=0;
// requests while busy=1 are dropped. done pulses for one cycle together with
// the pt update, and busy is already low in that cycle so a new start is taken.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic [127:0] pt,
  output logic         busy,
  output logic         done,
  output aes_state_e   dbg_state_o
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_cipher: NR must be 10 (AES-128 only)");
  end

  aes_state_e   state_q;
  logic [3:0]   rcnt_q;
  logic [127:0] ct_q, rk_q, st_q, pt_q;
  logic         busy_q, done_q;

  logic [7:0]   rc;
  logic [127:0] rk_fwd, rk_inv, imc_in, imc_out;

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] key_q, cache_key_q, cache_rk10_q;
  logic         cache_vld_q;
  logic         cache_hit;
  assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rcon, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recovers the previous round key from the next one.
  function automatic logic [127:0] inv_expand(input logic [127:0] n, input logic [7:0] rcon);
    logic [31:0] p0, p1, p2, p3;
    p3 = n[31:0]  ^ n[63:32];
    p2 = n[63:32] ^ n[95:64];
    p1 = n[95:64] ^ n[127:96];
    p0 = n[127:96] ^ sub_word(rot_word(p3)) ^ {rcon, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  always_comb begin
    rc     = rcon_at(rcnt_q);
    rk_fwd = fwd_expand(rk_q, rc);
    rk_inv = inv_expand(rk_q, rc);
    imc_in = '0;
    // InvShiftRows + InvSubBytes: row r of column c comes from column (c-r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        imc_in[127-8*(4*c+r) -: 8] = INV_SBOX[st_q[127-8*(4*((c+4-r)%4)+r) -: 8]];
      end
    end
    imc_in = imc_in ^ rk_q;
  end

  inv_mix_col u_inv_mix_col (
    .state_i(imc_in),
    .state_o(imc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= 4'd0;
      ct_q    <= '0;
      rk_q    <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
      key_q        <= '0;
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ct_q   <= ct;
            busy_q <= 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
            key_q <= key;
            if (cache_hit) begin
              rk_q    <= cache_rk10_q;
              rcnt_q  <= 4'(NR);
              state_q <= ARK0;
            end else begin
              rk_q    <= key;
              rcnt_q  <= 4'd1;
              state_q <= KEXP;
            end
`else
            rk_q    <= key;
            rcnt_q  <= 4'd1;
            state_q <= KEXP;
`endif
          end
        end
        KEXP: begin
          rk_q <= rk_fwd;
          // The counter parks at NR so it never leaves the 1..10 range.
          if (rcnt_q == 4'(NR)) begin
            state_q <= ARK0;
`ifdef AES_INV_KEY_CACHE_EN
            cache_key_q  <= key_q;
            cache_rk10_q <= rk_fwd;
            cache_vld_q  <= 1'b1;
`endif
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        ARK0: begin
          st_q    <= ct_q ^ rk_q;
          rk_q    <= rk_inv;
          rcnt_q  <= 4'(NR - 1);
          state_q <= ROUND;
        end
        ROUND: begin
          st_q   <= imc_out;
          rk_q   <= rk_inv;
          rcnt_q <= rcnt_q - 4'd1;
          if (rcnt_q == 4'd1) state_q <= FINAL;
        end
        FINAL: begin
          pt_q    <= imc_in;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pt          = pt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, back-to-back,
// ignored start, mid-operation reset and randomized vectors against a
// reference decryptor whose S-boxes are derived from GF(2^8) inversion.
module tb_aes_inv_cipher;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic [127:0] pt;
  logic         busy, done;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  aes_inv_cipher dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ct(ct), .key(key),
    .pt(pt), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  int           done_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] pt_exp;
  logic         cache_vld_m = 1'b0;
  logic [127:0] cache_key_m = '0;
  logic [7:0]   sb[256];
  logic [7:0]   isb[256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic init_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[a]  = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] cin, input logic [127:0] kin);
    logic [7:0]   kb[176];
    logic [7:0]   s[16], t[16], tw[4], coef[4];
    logic [7:0]   tmp, rc, acc;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) kb[i] = kin[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tw[j] = kb[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp   = tw[0];
        tw[0] = sb[tw[1]] ^ rc;
        tw[1] = sb[tw[2]];
        tw[2] = sb[tw[3]];
        tw[3] = sb[tmp];
        rc    = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) kb[4*i+j] = kb[4*(i-4)+j] ^ tw[j];
    end
    for (int i = 0; i < 16; i++) s[i] = cin[127-8*i -: 8] ^ kb[160+i];
    for (int r = 9; r >= 0; r--) begin
      // Rotate each row right by its row number, then inverse-substitute.
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[4*((col+row)%4)+row] = isb[s[4*col+row]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ kb[16*r+i];
      if (r > 0) begin
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(t[4*col+j], coef[(j-row+4)%4]);
            s[4*col+row] = acc;
          end
      end else begin
        s = t;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_INV_KEY_CACHE_EN
    if (cache_vld_m && k == cache_key_m) return 11;
`endif
    return 21;
  endfunction

  task automatic note_run(input logic [127:0] k);
    cache_vld_m = 1'b1;
    cache_key_m = k;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 128'(exp_q.size()), 128'd1);
      else begin
        pt_exp = exp_q.pop_front();
        check("pt", pt, pt_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_one(input logic [127:0] c_in, input logic [127:0] k_in,
                         input logic [127:0] p_exp, input int pulse_at, input string tag);
    int lat, n, busy_n, dc0;
    lat = exp_lat(k_in);
    note_run(k_in);
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; ct = c_in; key = k_in;
    exp_q.push_back(p_exp);
    @(posedge clk); #1;
    start = 1'b0; ct = rand128(); key = rand128();
    busy_n = busy ? 1 : 0;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy) busy_n++;
      start = (n == pulse_at);
      ct = rand128();
    end
    start = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'(lat));
    check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    check({tag, "_state_idle_at_done"}, 128'(dbg_state), 128'd0);
    repeat (30) @(posedge clk);
    #1;
    check({tag, "_pt_hold"}, pt, p_exp);
    check({tag, "_done_count"}, 128'(done_cnt - dc0), 128'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int l1, l2, n, m, dc0;
    logic [127:0] rk, rc_v;
    init_tables();

    repeat (3) @(posedge clk);
    #1;
    check("reset_pt", pt, 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    run_one(CT_C1, KEY_C1, PT_C1, 0, "c1");
    run_one(CT_C1, KEY_C1, PT_C1, 0, "c1_repeat");
    run_one(CT_B, KEY_B, PT_B, 0, "appb");

    // Back-to-back: start held high through the done cycle.
    l1 = exp_lat(KEY_B);  note_run(KEY_B);
    l2 = exp_lat(KEY_C1); note_run(KEY_C1);
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; ct = CT_B; key = KEY_B;
    exp_q.push_back(PT_B);
    exp_q.push_back(PT_C1);
    @(posedge clk); #1;
    ct = CT_C1; key = KEY_C1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (done) break;
    end
    check("b2b_first_latency", 128'(n), 128'(l1));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_no_gap", 128'(busy), 128'd1);
    m = 0;
    while (m < 100) begin
      @(posedge clk); #1; m++;
      if (done) break;
    end
    check("b2b_second_latency", 128'(m), 128'(l2));
    repeat (30) @(posedge clk);
    #1;
    check("b2b_done_count", 128'(done_cnt - dc0), 128'd2);

    // Start pulse during busy must be dropped.
    run_one(CT_B, KEY_B, PT_B, 5, "pulse");

    // Reset at cycle 12 of a run abandons it without done.
    @(negedge clk);
    start = 1'b1; ct = CT_C1; key = KEY_C1;
    exp_q.push_back(PT_C1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midreset_pt", pt, 128'd0);
    check("midreset_busy", 128'(busy), 128'd0);
    check("midreset_done", 128'(done), 128'd0);
    exp_q.delete();
    cache_vld_m = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("midreset_no_done", 128'(done_cnt - dc0), 128'd0);
    run_one(CT_C1, KEY_C1, PT_C1, 0, "c1_after_reset");

    // Randomized vectors, some reusing the previous key.
    rk = rand128();
    for (int i = 0; i < 8; i++) begin
      if (i % 3 != 2) rk = rand128();
      rc_v = rand128();
      run_one(rc_v, rk, model_decrypt(rc_v, rk), (i == 4) ? 3 : 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
